vermi_spi: RTL and testbench

VERMI_SPI -- requirements
Module: vermi_spi

---
 rtl/vermi_spi_pkg.sv | 20 ++
 rtl/vermi_spi_if.sv | 11 +
 rtl/vermi_spi_engine.sv | 86 ++++++++
 rtl/vermi_spi.sv | 81 ++++++++
 tb/tb_vermi_spi.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vermi_spi_pkg.sv
// vermi_spi_pkg: register map, FSM states and STATUS layout shared by the SPI master files
package vermi_spi_pkg;
  localparam logic [1:0] OFF_DATA    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CONTROL = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_IE   = 2;
  localparam logic [7:0] DEV_ADDR = 8'h82;
  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_e;
  function automatic logic [31:0] status_word(input logic ie, input logic done, input logic busy);
    logic [31:0] s;
    s = '0;
    s[ST_IE] = ie;
    s[ST_DONE] = done;
    s[ST_BUSY] = busy;
    return s;
  endfunction
endpackage

// File: rtl/vermi_spi_if.sv
// vermi_spi_if: zero-wait-state decoded data bus between a bus master and the SPI register block
interface vermi_spi_if;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output valid, address, wstrobe, wdata, input ready, rdata);
  modport slave (input valid, address, wstrobe, wdata, output ready, rdata);
endinterface

// File: rtl/vermi_spi_engine.sv
// vermi_spi_engine: SPI mode-0 MSB-first byte shifter with a per-transfer latched half-period divider
module vermi_spi_engine
  import vermi_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done_pulse
);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, div_q, div_d, tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, tick;
  assign tick = cnt_q == 8'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      tx_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end
  // div is captured at start so mid-transfer CONTROL writes wait for the next byte
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? div_q : cnt_q - 8'd1;
    div_d = div_q;
    tx_d = tx_q;
    sh_d = sh_q;
    rx_d = rx_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done_pulse = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = LEAD;
        div_d = div;
        cnt_d = div;
        tx_d = tx_byte;
        mosi_d = tx_byte[7];
        bit_d = '0;
      end
    end else if (tick) begin
      if (state_q == LEAD) begin
        state_d = TRAIL;
        sclk_d = 1'b1;
        sh_d = {sh_q[6:0], miso};
      end else begin
        sclk_d = 1'b0;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? IDLE : LEAD;
        rx_d = bit_q == 3'd7 ? sh_q : rx_q;
        done_pulse = bit_q == 3'd7;
        tx_d = bit_q == 3'd7 ? tx_q : {tx_q[6:0], 1'b0};
        mosi_d = bit_q == 3'd7 ? mosi_q : tx_q[6];
      end
    end
  end
  assign busy = state_q != IDLE;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign rx_byte = rx_q;
endmodule

// File: rtl/vermi_spi.sv
// vermi_spi: memory-mapped SPI master registers (DATA/STATUS/CONTROL) around vermi_spi_engine;
// define VERMI_SPI_IRQ_EN to enable the ie bit and the registered done interrupt
module vermi_spi
  import vermi_spi_pkg::*;
#(
  parameter int unsigned DIV_RESET = 4
) (
  input  logic clk,
  input  logic reset,
  vermi_spi_if.slave bus,
  output logic irq,
  output logic sclk,
  output logic mosi,
  input  logic miso,
  output logic cs_n
);
  localparam logic [7:0] DIV_INIT = 8'(DIV_RESET);
  logic [1:0] off;
  logic wr, rd, data_rd, start, busy, done_pulse, ie;
  logic done_q, done_d, cs_q, cs_d;
  logic [7:0] div_q, div_d, rx_byte;
  logic unused_bits;
  assign off = bus.address[3:2];
  assign wr = bus.valid & (|bus.wstrobe);
  assign rd = bus.valid & ~(|bus.wstrobe);
  assign data_rd = rd & (off == OFF_DATA);
  assign start = wr & bus.wstrobe[0] & (off == OFF_DATA) & ~busy;
  // completion in the same cycle as a DATA read keeps done set
  assign done_d = done_pulse | (done_q & ~data_rd);
  assign div_d = (wr & bus.wstrobe[0] & (off == OFF_CONTROL)) ? bus.wdata[7:0] : div_q;
  assign cs_d = (wr & bus.wstrobe[1] & (off == OFF_CONTROL)) ? bus.wdata[8] : cs_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      cs_q <= 1'b0;
      div_q <= DIV_INIT;
    end else begin
      done_q <= done_d;
      cs_q <= cs_d;
      div_q <= div_d;
    end
  end
`ifdef VERMI_SPI_IRQ_EN
  logic ie_q, ie_d, irq_q;
  assign ie_d = (wr & bus.wstrobe[0] & (off == OFF_STATUS)) ? bus.wdata[ST_IE] : ie_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q <= ie_d;
      irq_q <= done_q & ie_q & ~data_rd;
    end
  end
  assign ie = ie_q;
  assign irq = irq_q;
`else
  assign ie = 1'b0;
  assign irq = 1'b0;
`endif
  vermi_spi_engine u_engine (
    .clk(clk),
    .reset(reset),
    .start(start),
    .tx_byte(bus.wdata[7:0]),
    .div(div_q),
    .miso(miso),
    .busy(busy),
    .sclk(sclk),
    .mosi(mosi),
    .rx_byte(rx_byte),
    .done_pulse(done_pulse)
  );
  assign bus.ready = bus.valid & ~reset;
  assign bus.rdata = (~bus.valid | (off == OFF_RSVD)) ? '0 :
                     (off == OFF_DATA)   ? {24'b0, rx_byte} :
                     (off == OFF_STATUS) ? status_word(ie, done_q, busy) :
                                           {22'b0, cs_q, div_q};
  assign cs_n = ~cs_q;
  assign unused_bits = ^{bus.address[31:4], bus.address[1:0], bus.wdata[31:9], bus.wstrobe[3:2]};
endmodule

// File: tb/tb_vermi_spi.sv
// tb_vermi_spi: register table with a scoreboard queue plus loopback transfer, mid-transfer and reset sequences
module tb_vermi_spi;
  import vermi_spi_pkg::*;
`ifdef VERMI_SPI_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  typedef struct {
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] d;
    bit          is_rd;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic miso, irq, sclk, mosi, cs_n;
  logic last_rdy, last_irq;
  int total = 0;
  int bad = 0;
  int rises = 0;
  logic [7:0] mon = '0;
  logic [31:0] exp_q[$];
  vec_t tbl[16];
  vermi_spi_if bus();
  vermi_spi #(.DIV_RESET(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );
  assign miso = mosi;
  always #5 clk = ~clk;
  always @(posedge sclk) begin
    rises <= rises + 1;
    mon <= {mon[6:0], mosi};
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic bus_op(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.address = {28'h0, off, 2'b00};
    bus.wstrobe = strb;
    bus.wdata = d;
    #1;
    r = bus.rdata;
    last_rdy = bus.ready;
    last_irq = irq;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.wstrobe = '0;
  endtask
  task automatic rd(input logic [1:0] off, output logic [31:0] r);
    bus_op(off, 4'h0, 32'h0, r);
  endtask
  task automatic wr(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] d);
    logic [31:0] r;
    bus_op(off, strb, d, r);
  endtask
  task automatic poll(input int wr_at, input logic [31:0] wr_val, output int busy_cycles, output logic [31:0] st, output bit irq_seen);
    int n;
    irq_seen = 0;
    st = '0;
    for (n = 1; n <= 400; n++) begin
      if (n == wr_at) wr(OFF_DATA, 4'h1, wr_val);
      else begin
        rd(OFF_STATUS, st);
        if (!st[ST_BUSY]) break;
        irq_seen = irq_seen | last_irq;
      end
    end
    busy_cycles = n - 1;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r, st;
    int n, r0;
    bit seen;
    bus.valid = 1'b0;
    bus.address = '0;
    bus.wstrobe = '0;
    bus.wdata = '0;
    tbl[0]  = '{OFF_STATUS,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[1]  = '{OFF_CONTROL, 4'h0, 32'h0,          1'b1, 32'h4};
    tbl[2]  = '{OFF_CONTROL, 4'h2, 32'h100,        1'b0, 32'h0};
    tbl[3]  = '{OFF_CONTROL, 4'h0, 32'h0,          1'b1, 32'h104};
    tbl[4]  = '{OFF_RSVD,    4'h0, 32'h0,          1'b1, 32'h0};
    tbl[5]  = '{OFF_RSVD,    4'hF, 32'hFFFF_FFFF,  1'b0, 32'h0};
    tbl[6]  = '{OFF_RSVD,    4'h0, 32'h0,          1'b1, 32'h0};
    tbl[7]  = '{OFF_CONTROL, 4'h0, 32'h0,          1'b1, 32'h104};
    tbl[8]  = '{OFF_STATUS,  4'h1, 32'h6,          1'b0, 32'h0};
    tbl[9]  = '{OFF_STATUS,  4'h0, 32'h0,          1'b1, IRQ ? 32'h4 : 32'h0};
    tbl[10] = '{OFF_STATUS,  4'h1, 32'h0,          1'b0, 32'h0};
    tbl[11] = '{OFF_STATUS,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[12] = '{OFF_CONTROL, 4'h1, 32'hFFFF_FE00,  1'b0, 32'h0};
    tbl[13] = '{OFF_CONTROL, 4'h0, 32'h0,          1'b1, 32'h100};
    tbl[14] = '{OFF_CONTROL, 4'h2, 32'h0,          1'b0, 32'h0};
    tbl[15] = '{OFF_CONTROL, 4'h0, 32'h0,          1'b1, 32'h0};
    // reset state
    @(negedge clk);
    bus.valid = 1'b1;
    #1;
    chk("ready_in_reset", {31'b0, bus.ready}, 32'h0);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_sclk", {31'b0, sclk}, 32'h0);
    chk("reset_cs_n", {31'b0, cs_n}, 32'h1);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_mosi", {31'b0, mosi}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // register table through the scoreboard
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_rd) exp_q.push_back(tbl[i].exp);
      bus_op(tbl[i].off, tbl[i].strb, tbl[i].d, r);
      if (tbl[i].is_rd) chk($sformatf("tbl%0d", i), r, exp_q.pop_front());
      if (i == 0) chk("ready", {31'b0, last_rdy}, 32'h1);
      if (i == 3) chk("cs_n_lane1", {31'b0, cs_n}, 32'h0);
    end
    // loopback div=0
    r0 = rises;
    wr(OFF_DATA, 4'h1, 32'hA5);
    poll(0, 32'h0, n, st, seen);
    chk("A_busy_cycles", n, 16);
    chk("A_status_end", st, 32'h2);
    chk("A_rises", rises - r0, 8);
    chk("A_mosi", {24'b0, mon}, 32'hA5);
    rd(OFF_DATA, r);
    chk("A_data", r, 32'hA5);
    rd(OFF_STATUS, r);
    chk("A_done_cleared", r, 32'h0);
    chk("A_idle_sclk", {31'b0, sclk}, 32'h0);
    // div=3 with an ignored mid-transfer write
    wr(OFF_CONTROL, 4'h1, 32'h3);
    r0 = rises;
    wr(OFF_DATA, 4'h1, 32'h3C);
    poll(20, 32'hFF, n, st, seen);
    chk("B_busy_cycles", n, 64);
    chk("B_rises", rises - r0, 8);
    chk("B_mosi", {24'b0, mon}, 32'h3C);
    rd(OFF_DATA, r);
    chk("B_data", r, 32'h3C);
    rd(OFF_STATUS, r);
    rd(OFF_STATUS, r);
    chk("B_no_restart", r, 32'h0);
    // interrupt
    wr(OFF_CONTROL, 4'h1, 32'h0);
    wr(OFF_STATUS, 4'h1, 32'h4);
    wr(OFF_DATA, 4'h1, 32'h01);
    poll(0, 32'h0, n, st, seen);
    chk("C_irq_while_busy", {31'b0, seen}, 32'h0);
    chk("C_irq_with_done", {31'b0, last_irq}, 32'h0);
    rd(OFF_STATUS, r);
    chk("C_irq_rise", {31'b0, last_irq}, {31'b0, IRQ});
    chk("C_status", r, IRQ ? 32'h6 : 32'h2);
    rd(OFF_DATA, r);
    chk("C_data", r, 32'h01);
    rd(OFF_STATUS, r);
    chk("C_irq_drop", {31'b0, last_irq}, 32'h0);
    chk("C_status_after", r, IRQ ? 32'h4 : 32'h0);
    wr(OFF_STATUS, 4'h1, 32'h0);
    // reset in the middle of bit 4
    wr(OFF_CONTROL, 4'h2, 32'h100);
    wr(OFF_DATA, 4'h1, 32'h96);
    for (int k = 0; k < 9; k++) rd(OFF_STATUS, st);
    chk("D_busy_before", {31'b0, st[ST_BUSY]}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("D_sclk", {31'b0, sclk}, 32'h0);
    chk("D_cs_n", {31'b0, cs_n}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    rd(OFF_STATUS, r);
    chk("D_status", r, 32'h0);
    rd(OFF_CONTROL, r);
    chk("D_div_reset", r, 32'h4);
    wr(OFF_CONTROL, 4'h1, 32'h0);
    r0 = rises;
    wr(OFF_DATA, 4'h1, 32'h5A);
    poll(0, 32'h0, n, st, seen);
    chk("D_busy_cycles", n, 16);
    chk("D_rises", rises - r0, 8);
    rd(OFF_DATA, r);
    chk("D_data", r, 32'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
